pixel_sram_arbiter: RTL and testbench

Shares the single 8-bit framebuffer SRAM (320×240 = 76800 bytes, 17-bit address) between the pixel engine and the CPU-side framebuffer port, in the GPU `clkPixel` domain. The pixel engine has absolute priority: whenever it needs SRAM, its address passes straight through to the SRAM. CPU writes are absorbed in a small write FIFO and drained in free cycles. Free cycles are blanking and the odd display lines served from the pixel engine's line buffer. CPU reads are executed one at a time, after all buffered writes.

---
 rtl/pixel_sram_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_pixel_sram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sram_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_sram_arbiter
//
// Shares the single 8-bit framebuffer SRAM (320x240 bytes, 17-bit address)
// between the pixel engine and the CPU-side framebuffer port. Everything
// runs in the clkPixel domain.
//
// The pixel engine always wins: when pe_need is high its address goes
// straight to the SRAM with no register in the path. CPU writes are
// absorbed by a small circular FIFO and retired one per free cycle. A CPU
// read is held as a single pending request. It executes only in a free
// cycle with the write FIFO empty, so it always observes every write that
// was accepted before it.
//
// Slot priority, decided combinationally every cycle:
//   PE    : pe_need=1          -> sram_addr = pe_addr
//   WRITE : FIFO not empty     -> FIFO head to SRAM, head popped at the edge
//   READ  : read pending       -> sram_addr = rd_addr_q, data captured at edge
//   IDLE  : otherwise          -> sram_addr = pe_addr
//
// Ports
//   clkPixel      in   pixel clock, all state on rising edge
//   reset         in   synchronous, active-high
//   pe_need       in   pixel engine owns the SRAM this cycle
//   pe_addr       in   pixel engine address
//   pe_data       out  pixel engine read data (= sram_rdata)
//   cpu_wr_valid  in   CPU write request
//   cpu_wr_addr   in   CPU write address
//   cpu_wr_data   in   CPU write data
//   cpu_wr_ready  out  write FIFO can accept (low during reset)
//   cpu_rd_req    in   CPU read request pulse
//   cpu_rd_addr   in   CPU read address
//   cpu_rd_busy   out  a read is pending
//   cpu_rd_valid  out  one-cycle pulse, cpu_rd_data updated
//   cpu_rd_data   out  last read result, held until the next read completes
//   fifo_count    out  write FIFO occupancy
//   sram_addr     out  SRAM address
//   sram_wdata    out  SRAM write data
//   sram_we       out  SRAM write strobe, active-high
//   sram_rdata    in   asynchronous SRAM read data
// -----------------------------------------------------------------------------
module pixel_sram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17
) (
    input  logic                        clkPixel,
    input  logic                        reset,

    input  logic                        pe_need,
    input  logic [ADDR_W-1:0]           pe_addr,
    output logic [7:0]                  pe_data,

    input  logic                        cpu_wr_valid,
    input  logic [ADDR_W-1:0]           cpu_wr_addr,
    input  logic [7:0]                  cpu_wr_data,
    output logic                        cpu_wr_ready,

    input  logic                        cpu_rd_req,
    input  logic [ADDR_W-1:0]           cpu_rd_addr,
    output logic                        cpu_rd_busy,
    output logic                        cpu_rd_valid,
    output logic [7:0]                  cpu_rd_data,

    output logic [$clog2(FIFO_DEPTH):0] fifo_count,

    output logic [ADDR_W-1:0]           sram_addr,
    output logic [7:0]                  sram_wdata,
    output logic                        sram_we,
    input  logic [7:0]                  sram_rdata
);

    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_PE,
        SLOT_WRITE,
        SLOT_READ
    } slot_t;

    slot_t              slot;

    // Write FIFO storage (data only, never reset) and its control state.
    logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    // Pending read.
    logic               rd_pending;
    logic [ADDR_W-1:0]  rd_addr_q;

    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               rd_accept;

    // -------------------------------------------------------------------------
    // Slot decision. pe_need is used as-is; registering it would put the
    // pixel engine one cycle behind its own address.
    // -------------------------------------------------------------------------
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));

        slot = SLOT_IDLE;
        if (reset) begin
            // Nothing is issued to the SRAM in a reset cycle.
            slot = SLOT_IDLE;
        end else if (pe_need) begin
            slot = SLOT_PE;
        end else if (!fifo_empty) begin
            slot = SLOT_WRITE;
        end else if (rd_pending) begin
            // Only reached with the FIFO drained, which gives read-after-write
            // ordering for free.
            slot = SLOT_READ;
        end
    end

    // -------------------------------------------------------------------------
    // SRAM side and handshakes.
    // -------------------------------------------------------------------------
    always_comb begin
        sram_addr  = pe_addr;
        sram_wdata = '0;
        sram_we    = 1'b0;
        case (slot)
            SLOT_WRITE: begin
                sram_addr  = fifo_addr[rd_ptr];
                sram_wdata = fifo_data[rd_ptr];
                sram_we    = 1'b1;
            end
            SLOT_READ: begin
                sram_addr = rd_addr_q;
            end
            default: begin
                sram_addr = pe_addr;
            end
        endcase
    end

    // Ready looks only at occupancy: a full FIFO stays not-ready even in a
    // cycle where its head is being popped.
    assign cpu_wr_ready = !reset && !fifo_full;
    assign push         = cpu_wr_valid && cpu_wr_ready;
    assign pop          = (slot == SLOT_WRITE);

    // A request while one is already pending is dropped, not queued.
    assign rd_accept    = cpu_rd_req && !rd_pending;

    assign pe_data      = sram_rdata;
    assign cpu_rd_busy  = rd_pending;
    assign fifo_count   = count;

    // -------------------------------------------------------------------------
    // Control state: pointers, occupancy, read handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge clkPixel) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_pending   <= 1'b0;
            cpu_rd_valid <= 1'b0;
            cpu_rd_data  <= '0;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            cpu_rd_valid <= (slot == SLOT_READ);

            // rd_accept requires rd_pending=0 and the READ slot requires
            // rd_pending=1, so the two branches never compete.
            if (slot == SLOT_READ) begin
                cpu_rd_data <= sram_rdata;
                rd_pending  <= 1'b0;
            end else if (rd_accept) begin
                rd_pending  <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Data registers: FIFO entries and the latched read address.
    // -------------------------------------------------------------------------
    always_ff @(posedge clkPixel) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_wr_addr;
            fifo_data[wr_ptr] <= cpu_wr_data;
        end
        if (rd_accept) begin
            rd_addr_q <= cpu_rd_addr;
        end
    end

endmodule

// File: tb/tb_pixel_sram_arbiter.sv
module tb_pixel_sram_arbiter;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 17;

    logic              clkPixel = 1'b0;
    logic              reset    = 1'b1;
    logic              pe_need  = 1'b0;
    logic [16:0]       pe_addr  = '0;
    logic [7:0]        pe_data;
    logic              cpu_wr_valid = 1'b0;
    logic [16:0]       cpu_wr_addr  = '0;
    logic [7:0]        cpu_wr_data  = '0;
    logic              cpu_wr_ready;
    logic              cpu_rd_req   = 1'b0;
    logic [16:0]       cpu_rd_addr  = '0;
    logic              cpu_rd_busy;
    logic              cpu_rd_valid;
    logic [7:0]        cpu_rd_data;
    logic [2:0]        fifo_count;
    logic [16:0]       sram_addr;
    logic [7:0]        sram_wdata;
    logic              sram_we;
    logic [7:0]        sram_rdata;

    int total = 0;
    int bad   = 0;

    pixel_sram_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clkPixel     (clkPixel),
        .reset        (reset),
        .pe_need      (pe_need),
        .pe_addr      (pe_addr),
        .pe_data      (pe_data),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_rd_req   (cpu_rd_req),
        .cpu_rd_addr  (cpu_rd_addr),
        .cpu_rd_busy  (cpu_rd_busy),
        .cpu_rd_valid (cpu_rd_valid),
        .cpu_rd_data  (cpu_rd_data),
        .fifo_count   (fifo_count),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_we      (sram_we),
        .sram_rdata   (sram_rdata)
    );

    always #5 clkPixel = ~clkPixel;

    // Asynchronous-read SRAM model.
    logic [7:0] sram_mem [0:131071];
    logic [7:0] ref_mem  [0:131071];
    assign sram_rdata = sram_mem[sram_addr];
    always @(posedge clkPixel) begin
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clkPixel);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scoreboard / reference model, evaluated at every falling edge.
    // Accepted writes are pushed; they are popped when a WRITE slot is due.
    // ------------------------------------------------------------------
    typedef struct packed { logic [16:0] a; logic [7:0] d; } wr_t;
    wr_t         wq[$];
    bit          m_busy = 0;
    bit          m_valid = 0;
    logic [16:0] m_rd_addr = '0;
    logic [7:0]  m_rd_data = '0;
    bit          mon_en = 0;
    int          we_seen = 0;
    int          valid_seen = 0;

    always @(negedge clkPixel) begin
        bit          w_slot;
        bit          r_slot;
        bit          rdy;
        logic [16:0] ea;
        rdy    = !reset && (wq.size() != FIFO_DEPTH);
        w_slot = !reset && !pe_need && (wq.size() != 0);
        r_slot = !reset && !pe_need && (wq.size() == 0) && m_busy;
        ea = pe_addr;
        if (w_slot) ea = wq[0].a;
        if (r_slot) ea = m_rd_addr;

        check("sb_wr_ready", cpu_wr_ready, rdy);
        check("sb_sram_we", sram_we, w_slot);
        check("sb_sram_addr", sram_addr, ea);
        check("sb_pe_data", pe_data, sram_rdata);
        if (w_slot) check("sb_sram_wdata", sram_wdata, wq[0].d);
        if (reset)  check("sb_wdata_rst", sram_wdata, 0);
        if (mon_en) begin
            check("sb_fifo_count", fifo_count, wq.size());
            check("sb_rd_busy", cpu_rd_busy, m_busy);
            check("sb_rd_valid", cpu_rd_valid, m_valid);
            check("sb_rd_data", cpu_rd_data, m_rd_data);
        end
        if (sram_we) we_seen++;
        if (cpu_rd_valid) valid_seen++;

        if (reset) begin
            wq.delete();
            m_busy    = 0;
            m_valid   = 0;
            m_rd_data = '0;
            mon_en    = 1;
        end else begin
            m_valid = r_slot;
            if (r_slot) begin
                m_rd_data = ref_mem[m_rd_addr];
                m_busy    = 0;
            end else if (!m_busy && cpu_rd_req) begin
                m_busy    = 1;
                m_rd_addr = cpu_rd_addr;
            end
            if (w_slot) begin
                ref_mem[wq[0].a] = wq[0].d;
                void'(wq.pop_front());
            end
            if (cpu_wr_valid && rdy) wq.push_back({cpu_wr_addr, cpu_wr_data});
        end
    end

    // Table for the pe_need-hold / drain sequence.
    typedef struct {
        logic        pe;
        logic        wv;
        logic [16:0] wa;
        logic [7:0]  wd;
        logic [16:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_wd;
        logic [2:0]  exp_cnt;
        logic        exp_rdy;
    } vec_t;
    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int w0;
        bit got;

        for (int i = 0; i < 131072; i++) begin
            sram_mem[i] = i[7:0] ^ 8'h3C;
            ref_mem[i]  = i[7:0] ^ 8'h3C;
        end

        vt[0] = '{1'b1, 1'b1, 17'h00100, 8'h11, 17'h12BFF, 1'b0, 8'h00, 3'd0, 1'b1};
        vt[1] = '{1'b1, 1'b1, 17'h00101, 8'h22, 17'h12BFF, 1'b0, 8'h00, 3'd1, 1'b1};
        vt[2] = '{1'b1, 1'b1, 17'h00102, 8'h33, 17'h12BFF, 1'b0, 8'h00, 3'd2, 1'b1};
        vt[3] = '{1'b1, 1'b0, 17'h00000, 8'h00, 17'h12BFF, 1'b0, 8'h00, 3'd3, 1'b1};
        vt[4] = '{1'b0, 1'b0, 17'h00000, 8'h00, 17'h00100, 1'b1, 8'h11, 3'd3, 1'b1};
        vt[5] = '{1'b0, 1'b0, 17'h00000, 8'h00, 17'h00101, 1'b1, 8'h22, 3'd2, 1'b1};
        vt[6] = '{1'b0, 1'b0, 17'h00000, 8'h00, 17'h00102, 1'b1, 8'h33, 3'd1, 1'b1};
        vt[7] = '{1'b0, 1'b0, 17'h00000, 8'h00, 17'h12BFF, 1'b0, 8'h00, 3'd0, 1'b1};

        // Reset and idle.
        pe_addr = 17'h00A00;
        @(negedge clkPixel);
        check("rst_wr_ready", cpu_wr_ready, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 17'h00A00);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        @(negedge clkPixel);
        check("idle_ready", cpu_wr_ready, 1);
        check("idle_count", fifo_count, 0);
        check("idle_rd_busy", cpu_rd_busy, 0);
        check("idle_rd_valid", cpu_rd_valid, 0);
        check("idle_rd_data", cpu_rd_data, 0);
        check("idle_we_seen", we_seen, 0);
        step();

        // PE holds the SRAM while three writes queue up, then they drain.
        pe_addr = 17'h12BFF;
        foreach (vt[i]) begin
            pe_need      = vt[i].pe;
            cpu_wr_valid = vt[i].wv;
            cpu_wr_addr  = vt[i].wa;
            cpu_wr_data  = vt[i].wd;
            @(negedge clkPixel);
            check($sformatf("vec%0d_addr", i), sram_addr, vt[i].exp_addr);
            check($sformatf("vec%0d_we", i), sram_we, vt[i].exp_we);
            if (vt[i].exp_we) check($sformatf("vec%0d_wdata", i), sram_wdata, vt[i].exp_wd);
            check($sformatf("vec%0d_count", i), fifo_count, vt[i].exp_cnt);
            check($sformatf("vec%0d_ready", i), cpu_wr_ready, vt[i].exp_rdy);
            step();
        end

        // Five writes into a four-deep FIFO.
        pe_need = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 17'h00300 + 17'(i);
            cpu_wr_data  = 8'h50 + 8'(i);
            if (i < 4) begin
                @(negedge clkPixel);
                check("fill_ready", cpu_wr_ready, 1);
                step();
            end
        end
        @(negedge clkPixel);
        check("full_count", fifo_count, 4);
        check("full_ready", cpu_wr_ready, 0);
        step();
        @(negedge clkPixel);
        check("full_hold_ready", cpu_wr_ready, 0);
        step();
        pe_need = 1'b0;
        @(negedge clkPixel);
        check("full_pop_ready", cpu_wr_ready, 0);
        check("full_pop_we", sram_we, 1);
        check("full_pop_addr", sram_addr, 17'h00300);
        step();
        @(negedge clkPixel);
        check("after_pop_ready", cpu_wr_ready, 1);
        check("after_pop_count", fifo_count, 3);
        step();
        cpu_wr_valid = 1'b0;
        for (int k = 0; k < 20 && fifo_count != 0; k++) step();
        @(negedge clkPixel);
        check("drain_count", fifo_count, 0);
        check("drain_5th", sram_mem[17'h00304], 8'h54);
        step();

        // Write then read the same address while pe_need toggles.
        v0 = valid_seen;
        pe_need = 1'b1; cpu_wr_valid = 1'b1; cpu_wr_addr = 17'h00140; cpu_wr_data = 8'hA5;
        step();
        cpu_wr_valid = 1'b0; pe_need = 1'b0; cpu_rd_req = 1'b1; cpu_rd_addr = 17'h00140;
        @(negedge clkPixel);
        check("raw_write_slot", sram_we, 1);
        step();
        cpu_rd_req = 1'b0; pe_need = 1'b1;
        @(negedge clkPixel);
        check("raw_busy", cpu_rd_busy, 1);
        step();
        pe_need = 1'b0;
        @(negedge clkPixel);
        check("raw_read_addr", sram_addr, 17'h00140);
        check("raw_read_we", sram_we, 0);
        step();
        pe_need = 1'b1;
        @(negedge clkPixel);
        check("raw_valid", cpu_rd_valid, 1);
        check("raw_data", cpu_rd_data, 8'hA5);
        check("raw_busy_low", cpu_rd_busy, 0);
        step();
        pe_need = 1'b0;
        @(negedge clkPixel);
        check("raw_valid_pulse", cpu_rd_valid, 0);
        check("raw_valid_once", valid_seen - v0, 1);
        step();

        // Second request while busy is dropped.
        v0 = valid_seen;
        pe_need = 1'b1; cpu_rd_req = 1'b1; cpu_rd_addr = 17'h00100;
        step();
        cpu_rd_addr = 17'h00101;
        @(negedge clkPixel);
        check("busy2_busy", cpu_rd_busy, 1);
        step();
        cpu_rd_req = 1'b0; pe_need = 1'b0;
        for (int i = 0; i < 6; i++) step();
        @(negedge clkPixel);
        check("busy2_one_valid", valid_seen - v0, 1);
        check("busy2_data", cpu_rd_data, 8'h11);
        step();

        // Reset with two writes queued and a read pending.
        pe_need = 1'b1;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 17'h00200; cpu_wr_data = 8'hAA;
        step();
        cpu_wr_addr = 17'h00201; cpu_wr_data = 8'hBB;
        step();
        cpu_wr_valid = 1'b0; cpu_rd_req = 1'b1; cpu_rd_addr = 17'h00201;
        step();
        cpu_rd_req = 1'b0;
        @(negedge clkPixel);
        check("pre_rst_count", fifo_count, 2);
        check("pre_rst_busy", cpu_rd_busy, 1);
        step();
        v0 = valid_seen; w0 = we_seen;
        reset = 1'b1; pe_need = 1'b0;
        @(negedge clkPixel);
        check("mid_rst_we", sram_we, 0);
        check("mid_rst_ready", cpu_wr_ready, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        @(negedge clkPixel);
        check("post_rst_count", fifo_count, 0);
        check("post_rst_busy", cpu_rd_busy, 0);
        check("post_rst_no_we", we_seen - w0, 0);
        check("post_rst_no_valid", valid_seen - v0, 0);
        step();

        // The discarded write must not be in SRAM.
        cpu_rd_req = 1'b1; cpu_rd_addr = 17'h00200;
        step();
        cpu_rd_req = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clkPixel);
            if (cpu_rd_valid) got = 1;
            if (!got) step();
        end
        check("post_rst_rd_seen", got, 1);
        check("post_rst_rd_data", cpu_rd_data, 8'h3C);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
